// File: rtl/waiter_dispatch_unit_if.sv
// waiter_dispatch_unit_if: table-side inputs and front-of-house/payment outputs of the waiter dispatch unit
interface waiter_dispatch_unit_if;
  logic       table0_item_ready;
  logic [1:0] table0_ready_item;
  logic       table1_item_ready;
  logic [1:0] table1_ready_item;
  logic [7:0] table0_bill;
  logic [7:0] table1_bill;
  logic       table0_checkout_req;
  logic       table1_checkout_req;
  logic       table0_served;
  logic [1:0] table0_served_item;
  logic       table1_served;
  logic [1:0] table1_served_item;
  logic       waiter_busy;
  logic       waiter_table;
  logic [2:0] table0_fifo_count;
  logic [2:0] table1_fifo_count;
  logic       table0_overflow;
  logic       table1_overflow;
  logic       checkout_valid;
  logic       checkout_table;
  logic [7:0] checkout_amount;
  logic [7:0] table0_served_count;
  logic [7:0] table1_served_count;
  modport master (
    output table0_item_ready, table0_ready_item, table1_item_ready, table1_ready_item,
           table0_bill, table1_bill, table0_checkout_req, table1_checkout_req,
    input  table0_served, table0_served_item, table1_served, table1_served_item,
           waiter_busy, waiter_table, table0_fifo_count, table1_fifo_count,
           table0_overflow, table1_overflow, checkout_valid, checkout_table,
           checkout_amount, table0_served_count, table1_served_count
  );
  modport slave (
    input  table0_item_ready, table0_ready_item, table1_item_ready, table1_ready_item,
           table0_bill, table1_bill, table0_checkout_req, table1_checkout_req,
    output table0_served, table0_served_item, table1_served, table1_served_item,
           waiter_busy, waiter_table, table0_fifo_count, table1_fifo_count,
           table0_overflow, table1_overflow, checkout_valid, checkout_table,
           checkout_amount, table0_served_count, table1_served_count
  );
endinterface

// File: rtl/waiter_dispatch_unit.sv
// waiter_dispatch_unit: per-table item FIFOs, round-robin waiter delivery and checkout settlement.
// Optional served-item statistics are built when DINEFLOW_SERVE_STATS_EN is defined.
module waiter_dispatch_unit #(
  parameter int DELIVER_CYCLES = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input logic clk,
  input logic reset,
  waiter_dispatch_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DELIVER, SETTLE} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       tbl_q, tbl_d;
  logic [1:0] item_q, item_d;
  logic [7:0] amt_q, amt_d;
  logic [1:0] pend_q, ovf_q;
  logic [1:0] mem_q [2][4];
  logic [1:0] wp_q [2];
  logic [1:0] rp_q [2];
  logic [2:0] fc_q [2];
  logic [1:0] din [2];
  logic [7:0] bill [2];
  logic [1:0] rdy, req, full, elig, push, pop, clr, srv;
  assign rdy     = {bus.table1_item_ready, bus.table0_item_ready};
  assign req     = {bus.table1_checkout_req, bus.table0_checkout_req};
  assign din[0]  = bus.table0_ready_item;
  assign din[1]  = bus.table1_ready_item;
  assign bill[0] = bus.table0_bill;
  assign bill[1] = bus.table1_bill;
  assign full    = {fc_q[1] == 3'(FIFO_DEPTH), fc_q[0] == 3'(FIFO_DEPTH)};
  assign elig    = {fc_q[1] != 3'd0, fc_q[0] != 3'd0};
  assign push    = rdy & ~(full & ~pop);
  assign clr     = (state_q == SETTLE) ? 2'b01 << tbl_q : 2'b00;
  assign srv     = (state_q == DELIVER && cnt_q == 4'd0) ? 2'b01 << tbl_q : 2'b00;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    item_d  = item_q;
    amt_d   = amt_q;
    pop     = 2'b00;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          tbl_d   = &elig ? ~tbl_q : elig[1];
          pop     = 2'b01 << tbl_d;
          item_d  = mem_q[tbl_d][rp_q[tbl_d]];
          cnt_d   = 4'(DELIVER_CYCLES - 1);
          state_d = DELIVER;
        end else if (|pend_q) begin
          tbl_d   = &pend_q ? ~tbl_q : pend_q[1];
          amt_d   = bill[tbl_d];
          state_d = SETTLE;
        end
      end
      DELIVER: begin
        state_d = (cnt_q == 4'd0) ? IDLE : DELIVER;
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tbl_q   <= 1'b0;
      item_q  <= '0;
      amt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      for (int t = 0; t < 2; t++) begin
        wp_q[t] <= '0;
        rp_q[t] <= '0;
        fc_q[t] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      item_q  <= item_d;
      amt_q   <= amt_d;
      pend_q  <= (pend_q | req) & ~clr;
      ovf_q   <= ovf_q | (rdy & ~push);
      for (int t = 0; t < 2; t++) begin
        wp_q[t] <= wp_q[t] + {1'b0, push[t]};
        rp_q[t] <= rp_q[t] + {1'b0, pop[t]};
        fc_q[t] <= fc_q[t] + {2'b0, push[t]} - {2'b0, pop[t]};
      end
    end
  end
  // storage needs no reset: pointers and counts define which entries are live
  always_ff @(posedge clk) begin
    for (int t = 0; t < 2; t++)
      if (push[t]) mem_q[t][wp_q[t]] <= din[t];
  end
  assign bus.table0_served      = srv[0];
  assign bus.table1_served      = srv[1];
  assign bus.table0_served_item = srv[0] ? item_q : 2'b00;
  assign bus.table1_served_item = srv[1] ? item_q : 2'b00;
  assign bus.waiter_busy        = state_q != IDLE;
  assign bus.waiter_table       = tbl_q;
  assign bus.table0_fifo_count  = fc_q[0];
  assign bus.table1_fifo_count  = fc_q[1];
  assign bus.table0_overflow    = ovf_q[0];
  assign bus.table1_overflow    = ovf_q[1];
  assign bus.checkout_valid     = state_q == SETTLE;
  assign bus.checkout_table     = tbl_q;
  assign bus.checkout_amount    = amt_q;
`ifdef DINEFLOW_SERVE_STATS_EN
  logic [7:0] sc_q [2];
  always_ff @(posedge clk) begin
    for (int t = 0; t < 2; t++)
      if (reset) sc_q[t] <= '0;
      else if (srv[t] && sc_q[t] != 8'hFF) sc_q[t] <= sc_q[t] + 8'd1;
  end
  assign bus.table0_served_count = sc_q[0];
  assign bus.table1_served_count = sc_q[1];
`else
  assign bus.table0_served_count = 8'd0;
  assign bus.table1_served_count = 8'd0;
`endif
endmodule

// File: tb/tb_waiter_dispatch_unit.sv
// tb_waiter_dispatch_unit: directed vectors with hand-computed expectations for waiter_dispatch_unit
module tb_waiter_dispatch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [1:0] items [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  waiter_dispatch_unit_if bus();
  waiter_dispatch_unit #(.DELIVER_CYCLES(3), .FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask
  task automatic wait_srv(input bit t, output int n, output logic ok, output logic [1:0] it);
    n = 0;
    do begin
      tick;
      n++;
    end while (!(t ? bus.table1_served : bus.table0_served) && n < 40);
    ok = t ? bus.table1_served : bus.table0_served;
    it = t ? bus.table1_served_item : bus.table0_served_item;
  endtask
  initial begin
    int n;
    logic ok;
    logic [1:0] it;
    int seen;
    bus.table0_item_ready = 0; bus.table0_ready_item = 0;
    bus.table1_item_ready = 0; bus.table1_ready_item = 0;
    bus.table0_bill = 0; bus.table1_bill = 0;
    bus.table0_checkout_req = 0; bus.table1_checkout_req = 0;
    reset_dut;
    chk("rst_busy", bus.waiter_busy, 0);
    chk("rst_wtable", bus.waiter_table, 0);
    chk("rst_fc0", bus.table0_fifo_count, 0);
    chk("rst_fc1", bus.table1_fifo_count, 0);
    chk("rst_ovf", {bus.table1_overflow, bus.table0_overflow}, 0);
    chk("rst_cv", bus.checkout_valid, 0);
    chk("rst_amt", bus.checkout_amount, 0);
    chk("rst_srv", {bus.table1_served, bus.table0_served, bus.table1_served_item, bus.table0_served_item}, 0);
    chk("rst_scnt", {bus.table1_served_count, bus.table0_served_count}, 0);
    // single delivery on table 0
    bus.table0_item_ready = 1; bus.table0_ready_item = 2;
    tick;
    bus.table0_item_ready = 0;
    chk("t1_fc_vis", bus.table0_fifo_count, 1);
    chk("t1_idle", bus.waiter_busy, 0);
    tick;
    chk("t1_busy", bus.waiter_busy, 1);
    chk("t1_fc_pop", bus.table0_fifo_count, 0);
    wait_srv(0, n, ok, it);
    chk("t1_srv", ok, 1);
    chk("t1_lat", n, 2);
    chk("t1_item", it, 2);
    tick;
    chk("t1_done", bus.waiter_busy, 0);
`ifndef DINEFLOW_SERVE_STATS_EN
    chk("t1_scnt_off", bus.table0_served_count, 0);
`endif
    // simultaneous pushes: table 1 wins the first tie
    reset_dut;
    bus.table0_item_ready = 1; bus.table0_ready_item = 1;
    bus.table1_item_ready = 1; bus.table1_ready_item = 3;
    tick;
    bus.table0_item_ready = 0; bus.table1_item_ready = 0;
    wait_srv(1, n, ok, it);
    chk("t2_srv1", ok, 1);
    chk("t2_lat1", n, 3);
    chk("t2_item1", it, 3);
    chk("t2_wt1", bus.waiter_table, 1);
    wait_srv(0, n, ok, it);
    chk("t2_srv0", ok, 1);
    chk("t2_gap", n, 4);
    chk("t2_item0", it, 1);
    // overflow: fifth push meets a pop, sixth is dropped
    reset_dut;
    bus.table1_item_ready = 1; bus.table1_ready_item = 1;
    tick;
    bus.table1_item_ready = 0;
    for (int i = 0; i < 6; i++) begin
      bus.table0_item_ready = 1; bus.table0_ready_item = items[i];
      tick;
      if (i == 2) chk("t3_t1srv", {bus.table1_served, bus.table1_served_item}, 3'b101);
      if (i == 4) begin
        chk("t3_fc_pushpop", bus.table0_fifo_count, 4);
        chk("t3_no_ovf", bus.table0_overflow, 0);
      end
    end
    bus.table0_item_ready = 0;
    chk("t3_fc_full", bus.table0_fifo_count, 4);
    chk("t3_ovf", bus.table0_overflow, 1);
    for (int i = 0; i < 5; i++) begin
      wait_srv(0, n, ok, it);
      chk($sformatf("t3_drain%0d", i), {ok, it}, {1'b1, items[i]});
    end
    tick;
    chk("t3_fc_empty", bus.table0_fifo_count, 0);
    chk("t3_ovf_sticky", bus.table0_overflow, 1);
    chk("t3_ovf1", bus.table1_overflow, 0);
    // checkout waits for buffered items
    reset_dut;
    bus.table1_bill = 8'h5A; bus.table0_bill = 8'h11;
    bus.table1_item_ready = 1; bus.table1_ready_item = 2; bus.table1_checkout_req = 1;
    tick;
    bus.table1_checkout_req = 0; bus.table1_ready_item = 3;
    tick;
    bus.table1_item_ready = 0;
    chk("t4_fc_pushpop", bus.table1_fifo_count, 1);
    wait_srv(1, n, ok, it);
    chk("t4_srv_a", {ok, it}, 3'b110);
    chk("t4_cv_early", bus.checkout_valid, 0);
    wait_srv(1, n, ok, it);
    chk("t4_srv_b", {ok, it}, 3'b111);
    chk("t4_gap", n, 4);
    n = 0;
    do begin
      tick;
      n++;
    end while (!bus.checkout_valid && n < 20);
    chk("t4_cv", bus.checkout_valid, 1);
    chk("t4_cv_lat", n, 2);
    chk("t4_ctable", bus.checkout_table, 1);
    chk("t4_amt", bus.checkout_amount, 8'h5A);
    chk("t4_busy", bus.waiter_busy, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.checkout_valid) seen++;
    end
    chk("t4_pend_clr", seen, 0);
    chk("t4_idle", bus.waiter_busy, 0);
    // reset mid-delivery discards the item
    bus.table0_item_ready = 1; bus.table0_ready_item = 3;
    tick;
    bus.table0_item_ready = 0;
    tick;
    tick;
    chk("t5_in_deliver", bus.waiter_busy, 1);
    reset = 1;
    tick;
    reset = 0;
    chk("t5_busy", bus.waiter_busy, 0);
    chk("t5_fc", bus.table0_fifo_count, 0);
    chk("t5_srv", {bus.table0_served, bus.table0_served_item}, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.table0_served) seen++;
    end
    chk("t5_no_srv", seen, 0);
`ifdef DINEFLOW_SERVE_STATS_EN
    reset_dut;
    for (int i = 0; i < 260; i++) begin
      bus.table0_item_ready = 1; bus.table0_ready_item = 1;
      tick;
      bus.table0_item_ready = 0;
      wait_srv(0, n, ok, it);
      if (i == 0) chk("t6_first", bus.table0_served_count, 0);
    end
    tick;
    chk("t6_sat", bus.table0_served_count, 255);
    chk("t6_other", bus.table1_served_count, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
